// File: rtl/rx_frame_parser.sv
// GMII-style receive front end: strips preamble/SFD, forwards frame bytes with one cycle of delay,
// checks length and (when RX_CRC_CHECK_EN is defined) FCS, and holds the verdict for two CHECK cycles.
module rx_frame_parser #(
  parameter int pDATA_WIDTH = 8,
  parameter int pMIN_LEN    = 64,
  parameter int pMAX_LEN    = 1518,
  parameter int pLEN_W      = 11
) (
  input  logic                   iclk,
  input  logic                   i_rst,
  input  logic                   i_rx_dv,
  input  logic                   i_rx_er,
  input  logic [pDATA_WIDTH-1:0] i_rxd,
  output logic                   odv,
  output logic [pDATA_WIDTH-1:0] orx_d,
  output logic [2:0]             oFSM_state,
  output logic                   o_error,
  output logic [pLEN_W-1:0]      o_frame_len,
  output logic [15:0]            o_good_cnt,
  output logic [15:0]            o_bad_cnt
);

  localparam logic [2:0] ST_IDLE = 3'b000;
  localparam logic [2:0] ST_PRE  = 3'b001;
  localparam logic [2:0] ST_DATA = 3'b010;
  localparam logic [2:0] ST_CHK  = 3'b011;
  localparam logic [2:0] ST_DROP = 3'b100;

  localparam logic [pLEN_W-1:0] MIN_LEN   = pLEN_W'(pMIN_LEN);
  localparam logic [pLEN_W-1:0] OVER_LEN  = pLEN_W'(pMAX_LEN + 1);

  logic [2:0]             state_q, state_d;
  logic                   chk_q, chk_d;
  logic                   odv_q, odv_d;
  logic [pDATA_WIDTH-1:0] rxd_q, rxd_d;
  logic                   err_q, err_d;
  logic [pLEN_W-1:0]      len_q, len_d;
  logic [15:0]            good_q, good_d, bad_q, bad_d;
  logic [pLEN_W-1:0]      len_inc;
  logic                   sfd_hit;
  logic                   fcs_bad;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign len_inc = len_q + 1'b1;
  assign sfd_hit = (state_q == ST_PRE) && i_rx_dv && !i_rx_er && (i_rxd == 8'hD5);

`ifdef RX_CRC_CHECK_EN
  logic [31:0] crc_q, crc_d;

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (sfd_hit) begin
      crc_d = 32'hFFFFFFFF;
    end else if (state_q == ST_DATA && i_rx_dv) begin
      crc_d = crc_byte(crc_q, i_rxd);
    end
  end

  always_ff @(posedge iclk or posedge i_rst) begin
    if (i_rst) crc_q <= 32'hFFFFFFFF;
    else       crc_q <= crc_d;
  end

  // Running the CRC over the received FCS leaves the fixed residue when the frame is intact.
  assign fcs_bad = (crc_q != 32'hDEBB20E3);
`else
  assign fcs_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    chk_d   = 1'b0;
    odv_d   = 1'b0;
    rxd_d   = i_rxd;
    err_d   = err_q;
    len_d   = len_q;
    good_d  = good_q;
    bad_d   = bad_q;
    case (state_q)
      ST_IDLE: begin
        if (i_rx_dv && i_rxd == 8'h55) begin
          state_d = ST_PRE;
          err_d   = 1'b0;
        end
      end
      ST_PRE: begin
        if (sfd_hit) begin
          state_d = ST_DATA;
          len_d   = '0;
        end else if (!i_rx_dv || i_rx_er || i_rxd != 8'h55) begin
          state_d = ST_IDLE;
          err_d   = 1'b0;
        end
      end
      ST_DATA: begin
        if (!i_rx_dv) begin
          state_d = ST_CHK;
          err_d   = (len_q < MIN_LEN) | fcs_bad;
        end else begin
          len_d = len_inc;
          // Line error and overflow on the same byte still make a single DROP entry.
          if (i_rx_er || len_inc == OVER_LEN) begin
            state_d = ST_DROP;
            err_d   = 1'b1;
            bad_d   = sat_inc(bad_q);
          end else begin
            odv_d = 1'b1;
          end
        end
      end
      ST_CHK: begin
        if (!chk_q) begin
          chk_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
          err_d   = 1'b0;
          if (err_q) bad_d  = sat_inc(bad_q);
          else       good_d = sat_inc(good_q);
        end
      end
      ST_DROP: begin
        if (!i_rx_dv) begin
          state_d = ST_IDLE;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iclk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      chk_q   <= 1'b0;
      odv_q   <= 1'b0;
      rxd_q   <= '0;
      err_q   <= 1'b0;
      len_q   <= '0;
      good_q  <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      chk_q   <= chk_d;
      odv_q   <= odv_d;
      rxd_q   <= rxd_d;
      err_q   <= err_d;
      len_q   <= len_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
    end
  end

  assign oFSM_state  = state_q;
  assign odv         = odv_q;
  assign orx_d       = rxd_q;
  assign o_error     = err_q;
  assign o_frame_len = len_q;
  assign o_good_cnt  = good_q;
  assign o_bad_cnt   = bad_q;

endmodule

// File: tb/tb_rx_frame_parser.sv
// Bench for rx_frame_parser: frames built from random bytes with a computed FCS, outcome predicted per frame.
module tb_rx_frame_parser;

  localparam int MINL = 64;
  localparam int MAXL = 1518;
  localparam logic [2:0] S_IDLE = 3'b000, S_PRE = 3'b001, S_DATA = 3'b010,
                         S_CHK = 3'b011, S_DROP = 3'b100;
`ifdef RX_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        iclk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_rx_dv = 1'b0;
  logic        i_rx_er = 1'b0;
  logic [7:0]  i_rxd = 8'h00;
  logic        odv, o_error;
  logic [7:0]  orx_d;
  logic [2:0]  oFSM_state;
  logic [10:0] o_frame_len;
  logic [15:0] o_good_cnt, o_bad_cnt;

  int total = 0;
  int bad = 0;

  always #5 iclk = ~iclk;

  rx_frame_parser dut (
    .iclk(iclk), .i_rst(i_rst), .i_rx_dv(i_rx_dv), .i_rx_er(i_rx_er), .i_rxd(i_rxd),
    .odv(odv), .orx_d(orx_d), .oFSM_state(oFSM_state), .o_error(o_error),
    .o_frame_len(o_frame_len), .o_good_cnt(o_good_cnt), .o_bad_cnt(o_bad_cnt)
  );

  logic [7:0] pay_q[$];
  logic [7:0] got_q[$];
  int   chk_n, drop_n, drop_bad, odv_bad, len_seen;
  logic chk_e0, chk_e1;
  logic [2:0] st_after_er, st_after_fall;
  logic odv_after_er, err_after_er;
  int   good_m = 0, bad_m = 0;
  int   exp_len, exp_nout;
  bit   exp_err, exp_drop;

  function automatic logic [31:0] fcs_of_pay();
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (pay_q[i]) begin
      c ^= {24'd0, pay_q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // n bytes total: n-4 random payload bytes followed by the FCS, least significant byte first.
  task automatic build_frame(input int n, input bit corrupt);
    logic [31:0] f;
    pay_q.delete();
    for (int i = 0; i < n - 4; i++) pay_q.push_back(8'($urandom));
    f = fcs_of_pay();
    for (int i = 0; i < 4; i++) pay_q.push_back(f[8*i +: 8]);
    if (corrupt) pay_q[pay_q.size()-1] = pay_q[pay_q.size()-1] ^ 8'h01;
  endtask

  // Frame-level prediction: where (if anywhere) the frame is dropped, what length and verdict result.
  task automatic model_frame(input int er_at, input bit corrupt);
    int n = pay_q.size();
    int p = 0;
    if (er_at >= 0 && er_at < n) p = er_at + 1;
    if (n > MAXL && (p == 0 || p > MAXL + 1)) p = MAXL + 1;
    exp_drop = (p != 0);
    if (exp_drop) begin
      exp_len = p; exp_nout = p - 1; exp_err = 1'b1;
      if (bad_m < 65535) bad_m++;
    end else begin
      exp_len = n; exp_nout = n;
      exp_err = (n < MINL) || (CRC_EN && corrupt);
      if (exp_err) begin if (bad_m < 65535) bad_m++; end
      else begin if (good_m < 65535) good_m++; end
    end
  endtask

  function automatic int byte_mism();
    int m = 0;
    foreach (got_q[i]) if (i >= pay_q.size() || got_q[i] !== pay_q[i]) m++;
    return m;
  endfunction

  task automatic obs();
    if (oFSM_state == S_DATA) begin chk_n = 0; drop_n = 0; end
    if (odv) begin
      got_q.push_back(orx_d);
      if (oFSM_state != S_DATA) odv_bad++;
    end
    if (oFSM_state == S_CHK) begin
      if (chk_n == 0) begin chk_e0 = o_error; len_seen = int'(o_frame_len); end
      else chk_e1 = o_error;
      chk_n++;
    end
    if (oFSM_state == S_DROP) begin
      if (drop_n == 0) len_seen = int'(o_frame_len);
      if (!o_error || odv) drop_bad++;
      drop_n++;
    end
  endtask

  task automatic cyc(input logic dv, input logic er, input logic [7:0] d);
    i_rx_dv = dv; i_rx_er = er; i_rxd = d;
    @(posedge iclk); #1;
    obs();
  endtask

  task automatic run_frame(input int npre, input int er_at, input int gap);
    got_q.delete();
    chk_n = 0; drop_n = 0; drop_bad = 0; odv_bad = 0; len_seen = -1;
    for (int i = 0; i < npre; i++) cyc(1'b1, 1'b0, 8'h55);
    cyc(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < pay_q.size(); i++) begin
      cyc(1'b1, (i == er_at), pay_q[i]);
      if (i == er_at) begin st_after_er = oFSM_state; odv_after_er = odv; err_after_er = o_error; end
    end
    cyc(1'b0, 1'b0, 8'h00);
    st_after_fall = oFSM_state;
    for (int i = 1; i < gap; i++) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge iclk);
    #1;
    total++;
    if (oFSM_state !== S_IDLE || odv !== 1'b0 || orx_d !== 8'h00 || o_error !== 1'b0 ||
        o_frame_len !== 11'd0 || o_good_cnt !== 16'd0 || o_bad_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_state got st=%0d odv=%0b d=%0h err=%0b len=%0d g=%0d b=%0d want all zero",
               oFSM_state, odv, orx_d, o_error, o_frame_len, o_good_cnt, o_bad_cnt);
    end
    i_rst = 1'b0;
    @(posedge iclk); #1;
  endtask

  task automatic test_good_frame();
    build_frame(64, 1'b0); model_frame(-1, 1'b0); run_frame(7, -1, 4);
    total++; if (got_q.size() != 64) begin bad++; $display("FAIL good_odv_count got=%0d exp=64", got_q.size()); end
    total++; if (byte_mism() != 0) begin bad++; $display("FAIL good_bytes mismatched=%0d exp=0", byte_mism()); end
    total++; if (len_seen != 64) begin bad++; $display("FAIL good_len got=%0d exp=64", len_seen); end
    total++; if (chk_n != 2 || chk_e0 !== 1'b0 || chk_e1 !== 1'b0) begin
      bad++; $display("FAIL good_check cycles=%0d err=%0b%0b exp 2 cycles err=00", chk_n, chk_e0, chk_e1); end
    total++; if (st_after_fall !== S_CHK) begin bad++; $display("FAIL good_fall_state got=%0d exp=3", st_after_fall); end
    total++; if (o_good_cnt !== 16'(good_m) || o_good_cnt !== 16'd1) begin
      bad++; $display("FAIL good_cnt got=%0d exp=1", o_good_cnt); end
  endtask

  task automatic test_bad_fcs();
    build_frame(64, 1'b1); model_frame(-1, 1'b1); run_frame(7, -1, 4);
    total++; if (chk_n != 2 || chk_e0 !== exp_err || chk_e1 !== exp_err) begin
      bad++; $display("FAIL fcs_check cycles=%0d err=%0b%0b exp err=%0b", chk_n, chk_e0, chk_e1, exp_err); end
    total++; if (o_good_cnt !== 16'(good_m) || o_bad_cnt !== 16'(bad_m)) begin
      bad++; $display("FAIL fcs_counts got g=%0d b=%0d exp g=%0d b=%0d", o_good_cnt, o_bad_cnt, good_m, bad_m); end
  endtask

  task automatic test_runt();
    build_frame(40, 1'b0); model_frame(-1, 1'b0); run_frame(3, -1, 4);
    total++; if (chk_n != 2 || chk_e0 !== 1'b1 || chk_e1 !== 1'b1) begin
      bad++; $display("FAIL runt_check cycles=%0d err=%0b%0b exp err=11", chk_n, chk_e0, chk_e1); end
    total++; if (len_seen != 40) begin bad++; $display("FAIL runt_len got=%0d exp=40", len_seen); end
    total++; if (o_bad_cnt !== 16'(bad_m)) begin bad++; $display("FAIL runt_bad_cnt got=%0d exp=%0d", o_bad_cnt, bad_m); end
  endtask

  task automatic test_rx_er();
    build_frame(64, 1'b0); model_frame(19, 1'b0); run_frame(7, 19, 4);
    total++; if (st_after_er !== S_DROP || odv_after_er !== 1'b0 || err_after_er !== 1'b1) begin
      bad++; $display("FAIL er_drop got st=%0d odv=%0b err=%0b exp st=4 odv=0 err=1", st_after_er, odv_after_er, err_after_er); end
    total++; if (st_after_fall !== S_IDLE) begin bad++; $display("FAIL er_return got=%0d exp=0", st_after_fall); end
    total++; if (got_q.size() != 19 || chk_n != 0 || drop_bad != 0) begin
      bad++; $display("FAIL er_frame odv=%0d chk=%0d dropbad=%0d exp 19 0 0", got_q.size(), chk_n, drop_bad); end
    total++; if (o_bad_cnt !== 16'(bad_m)) begin bad++; $display("FAIL er_bad_cnt got=%0d exp=%0d", o_bad_cnt, bad_m); end
  endtask

  task automatic test_overflow();
    build_frame(1600, 1'b0); model_frame(-1, 1'b0); run_frame(7, -1, 4);
    total++; if (len_seen != MAXL + 1) begin bad++; $display("FAIL ovf_len got=%0d exp=%0d", len_seen, MAXL + 1); end
    total++; if (got_q.size() != MAXL || drop_n == 0 || drop_bad != 0) begin
      bad++; $display("FAIL ovf_frame odv=%0d drop=%0d dropbad=%0d exp odv=%0d", got_q.size(), drop_n, drop_bad, MAXL); end
    total++; if (o_bad_cnt !== 16'(bad_m) || o_good_cnt !== 16'(good_m)) begin
      bad++; $display("FAIL ovf_counts got g=%0d b=%0d exp g=%0d b=%0d", o_good_cnt, o_bad_cnt, good_m, bad_m); end
  endtask

  task automatic test_back_to_back();
    build_frame(70, 1'b0); model_frame(-1, 1'b0); run_frame(7, -1, 1);
    build_frame(66, 1'b0); model_frame(-1, 1'b0); run_frame(7, -1, 4);
    total++; if (got_q.size() != 66 || byte_mism() != 0) begin
      bad++; $display("FAIL b2b_bytes odv=%0d mism=%0d exp 66 0", got_q.size(), byte_mism()); end
    total++; if (chk_n != 2 || chk_e0 !== 1'b0 || len_seen != 66) begin
      bad++; $display("FAIL b2b_check cycles=%0d err=%0b len=%0d exp 2 0 66", chk_n, chk_e0, len_seen); end
    total++; if (o_good_cnt !== 16'(good_m)) begin bad++; $display("FAIL b2b_good_cnt got=%0d exp=%0d", o_good_cnt, good_m); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 24; f++) begin
      int n = $urandom_range(20, 140);
      bit cor = ($urandom_range(0, 3) == 0);
      int er = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      build_frame(n, cor); model_frame(er, cor); run_frame($urandom_range(1, 7), er, 4);
      total++; if (got_q.size() != exp_nout || byte_mism() != 0) begin
        bad++; $display("FAIL rnd%0d_bytes odv=%0d mism=%0d exp odv=%0d", f, got_q.size(), byte_mism(), exp_nout); end
      total++; if (len_seen != exp_len) begin bad++; $display("FAIL rnd%0d_len got=%0d exp=%0d", f, len_seen, exp_len); end
      total++;
      if (exp_drop ? (drop_n == 0 || drop_bad != 0 || chk_n != 0)
                   : (chk_n != 2 || chk_e0 !== exp_err || chk_e1 !== exp_err)) begin
        bad++; $display("FAIL rnd%0d_verdict chk=%0d err=%0b%0b drop=%0d exp drop=%0b err=%0b",
                        f, chk_n, chk_e0, chk_e1, drop_n, exp_drop, exp_err);
      end
      total++; if (odv_bad != 0) begin bad++; $display("FAIL rnd%0d_odv_outside_data got=%0d exp=0", f, odv_bad); end
      total++; if (o_good_cnt !== 16'(good_m) || o_bad_cnt !== 16'(bad_m)) begin
        bad++; $display("FAIL rnd%0d_counts got g=%0d b=%0d exp g=%0d b=%0d", f, o_good_cnt, o_bad_cnt, good_m, bad_m); end
    end
  endtask

  task automatic test_reset_mid();
    build_frame(80, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 8'h55);
    cyc(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 30; i++) cyc(1'b1, 1'b0, pay_q[i]);
    #2;
    i_rst = 1'b1; i_rx_dv = 1'b0;
    #1;
    total++;
    if (oFSM_state !== S_IDLE || odv !== 1'b0 || orx_d !== 8'h00 || o_error !== 1'b0 ||
        o_frame_len !== 11'd0 || o_good_cnt !== 16'd0 || o_bad_cnt !== 16'd0) begin
      bad++;
      $display("FAIL midreset_state got st=%0d odv=%0b d=%0h err=%0b len=%0d g=%0d b=%0d want all zero",
               oFSM_state, odv, orx_d, o_error, o_frame_len, o_good_cnt, o_bad_cnt);
    end
    @(posedge iclk); #1;
    i_rst = 1'b0;
    good_m = 0; bad_m = 0;
    build_frame(64, 1'b0); model_frame(-1, 1'b0); run_frame(7, -1, 4);
    total++; if (got_q.size() != 64 || byte_mism() != 0 || chk_e0 !== 1'b0) begin
      bad++; $display("FAIL midreset_frame odv=%0d mism=%0d err=%0b exp 64 0 0", got_q.size(), byte_mism(), chk_e0); end
    total++; if (o_good_cnt !== 16'd1 || o_bad_cnt !== 16'd0) begin
      bad++; $display("FAIL midreset_counts got g=%0d b=%0d exp g=1 b=0", o_good_cnt, o_bad_cnt); end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_good_frame();
    test_bad_fcs();
    test_runt();
    test_rx_er();
    test_overflow();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
